// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver using 16x oversampling: recovers bytes from the rx pin and
// reports each good byte (rx_done), each framing error (frame_err) and line activity (busy).
module uart_rx_oversample #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = $clog2(DIV + 1);
  localparam int N_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [N_W-1:0]   N_LAST   = N_W'(DATA_BITS - 1);
  localparam logic [3:0]       S_MID    = 4'd7;
  localparam logic [3:0]       S_END    = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;

  state_t               state_q, state_d;
  logic [3:0]           s_cnt_q, s_cnt_d;
  logic [N_W-1:0]       n_cnt_q, n_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  // Two-flop synchronizer; resets to the idle-high line level.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                        div_cnt <= div_cnt + DIV_W'(1);
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tick && !rx_s) begin
          state_d = S_START;
          s_cnt_d = '0;
        end
      end

      S_START: begin
        if (tick) begin
          if (s_cnt_q == S_MID) begin
            // A high line at mid start bit was a glitch, not a frame.
            if (!rx_s) begin
              state_d = S_DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (s_cnt_q == S_END) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) state_d = S_STOP;
            else                   n_cnt_d = n_cnt_q + N_W'(1);
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          if (s_cnt_q == S_END) begin
            if (rx_s) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end

      // Not tick-gated: wait out a low line so one break gives one frame_err.
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign data_out  = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);

endmodule
